half_shell_pair_scheduler: RTL and testbench

Sequences position-cache reads for one force-evaluation iteration using half-shell neighbour selection. All cells run in lockstep. For each reference particle of the home cell, the block sweeps neighbour slot 0 (home) and slots 1..13, which are the position-cache-to-PE mapping outputs. It issues one reference/neighbour pair per cycle to every PE. It sits between the iteration controller (start/done) and the position caches plus PE inputs, and drives the per-slot select that picks among the 14 mapped readouts.

---
 rtl/md_sched_pkg.sv | 13 +
 rtl/valid_delay_line.sv | 43 ++++
 rtl/half_shell_pair_scheduler.sv | 167 ++++++++++++++++
 tb/tb_half_shell_pair_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared types and defaults for the half-shell pair scheduler.
package md_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int SCHED_SEL_WIDTH          = 4;
    localparam int SCHED_NUM_NEIGHBOR_CELLS = 13;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register carrying {valid, sel, last} alongside position-cache reads.
module valid_delay_line #(
    parameter int DEPTH = 1,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_last,
    output logic             out_valid,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_last,
    output logic             empty
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] lst;
    logic [SEL_W-1:0] sel [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            lst <= '0;
            for (int i = 0; i < DEPTH; i++) sel[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            lst[0] <= in_last;
            sel[0] <= in_sel;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                lst[i] <= lst[i-1];
                sel[i] <= sel[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_last  = lst[DEPTH-1];
    assign out_sel   = sel[DEPTH-1];
    assign empty     = ~|vld;

endmodule

// File: rtl/half_shell_pair_scheduler.sv
// Issues reference/neighbour read pairs over home + half-shell slots for one iteration.
// Optional feature macro PAIR_COUNT_EN adds a saturating pair_count output.
module half_shell_pair_scheduler
    import md_sched_pkg::*;
#(
    parameter int NUM_NEIGHBOR_CELLS = SCHED_NUM_NEIGHBOR_CELLS,
    parameter int PARTICLE_ID_WIDTH  = 7,
    parameter int RD_LATENCY         = 1,
    parameter int SEL_WIDTH          = SCHED_SEL_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PARTICLE_ID_WIDTH:0]   num_particles,
    input  logic                         pe_ready,
    output logic                         ref_rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_rd_addr,
    output logic                         nb_rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0] nb_rd_addr,
    output logic [SEL_WIDTH-1:0]         nb_sel,
    output logic                         pair_valid,
    output logic                         ref_last,
    output logic                         busy,
`ifdef PAIR_COUNT_EN
    output logic [31:0]                  pair_count,
`endif
    output logic                         done
);

    localparam int NW = PARTICLE_ID_WIDTH + 1;
    localparam logic [SEL_WIDTH-1:0]         LAST_SLOT = SEL_WIDTH'(NUM_NEIGHBOR_CELLS);
    localparam logic [SEL_WIDTH-1:0]         SLOT_ONE  = SEL_WIDTH'(1);
    localparam logic [NW-1:0]                CNT_ZERO  = NW'(0);
    localparam logic [NW-1:0]                CNT_ONE   = NW'(1);
    localparam logic [NW-1:0]                CNT_TWO   = NW'(2);
    localparam logic [PARTICLE_ID_WIDTH-1:0] ID_ONE    = PARTICLE_ID_WIDTH'(1);
    localparam logic [PARTICLE_ID_WIDTH-1:0] ID_TWO    = PARTICLE_ID_WIDTH'(2);

    sched_state_t                 state_q, state_d;
    logic [NW-1:0]                np_q, np_d;
    logic [PARTICLE_ID_WIDTH-1:0] r_q, r_d, p_q, p_d;
    logic [SEL_WIDTH-1:0]         n_q, n_d;

    logic issue, p_last, r_last, home_empty_next, last_issue_pair, dl_empty;

    assign issue           = (state_q == RUN) && pe_ready;
    assign p_last          = ({1'b0, p_q} + CNT_ONE) == np_q;
    assign r_last          = ({1'b0, r_q} + CNT_ONE) == np_q;
    // Next reference's home range (r+2..N-1) is empty when r+2 == N.
    assign home_empty_next = ({1'b0, r_q} + CNT_TWO) == np_q;
    assign last_issue_pair = (n_q == LAST_SLOT) && p_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            np_q    <= '0;
            r_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            np_q    <= np_d;
            r_q     <= r_d;
            n_q     <= n_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        np_d    = np_q;
        r_d     = r_q;
        n_d     = n_q;
        p_d     = p_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    np_d = num_particles;
                    r_d  = '0;
                    if (num_particles == CNT_ZERO) begin
                        state_d = DRAIN;
                        n_d     = '0;
                        p_d     = '0;
                    end else if (num_particles == CNT_ONE) begin
                        state_d = RUN;
                        n_d     = SLOT_ONE;
                        p_d     = '0;
                    end else begin
                        state_d = RUN;
                        n_d     = '0;
                        p_d     = ID_ONE;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    if (!p_last) begin
                        p_d = p_q + ID_ONE;
                    end else if (n_q != LAST_SLOT) begin
                        n_d = n_q + SLOT_ONE;
                        p_d = '0;
                    end else if (r_last) begin
                        state_d = DRAIN;
                        r_d     = '0;
                        n_d     = '0;
                        p_d     = '0;
                    end else begin
                        r_d = r_q + ID_ONE;
                        if (home_empty_next) begin
                            n_d = SLOT_ONE;
                            p_d = '0;
                        end else begin
                            n_d = '0;
                            p_d = r_q + ID_TWO;
                        end
                    end
                end
            end
            DRAIN: begin
                if (dl_empty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ref_rd_en   = issue;
    assign nb_rd_en    = issue;
    assign ref_rd_addr = issue ? r_q : '0;
    assign nb_rd_addr  = issue ? p_q : '0;
    assign busy        = (state_q != IDLE);

    valid_delay_line #(
        .DEPTH (RD_LATENCY),
        .SEL_W (SEL_WIDTH)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_sel    (issue ? n_q : '0),
        .in_last   (issue && last_issue_pair),
        .out_valid (pair_valid),
        .out_sel   (nb_sel),
        .out_last  (ref_last),
        .empty     (dl_empty)
    );

`ifdef PAIR_COUNT_EN
    logic [31:0] pair_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_cnt_q <= '0;
        end else if (state_q == IDLE && start) begin
            pair_cnt_q <= '0;
        end else if (pair_valid && (pair_cnt_q != '1)) begin
            pair_cnt_q <= pair_cnt_q + 32'd1;
        end
    end

    assign pair_count = pair_cnt_q;
`endif

endmodule

// File: tb/tb_half_shell_pair_scheduler.sv
// Directed bench for half_shell_pair_scheduler; define PAIR_COUNT_EN to also check pair_count.
module tb_half_shell_pair_scheduler;

    localparam int PID_W  = 7;
    localparam int SEL_W  = 4;
    localparam int RD_LAT = 1;
    localparam int NB     = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PID_W:0]   num_particles;
    logic             pe_ready;
    logic             ref_rd_en, nb_rd_en, pair_valid, ref_last, busy, done;
    logic [PID_W-1:0] ref_rd_addr, nb_rd_addr;
    logic [SEL_W-1:0] nb_sel;
`ifdef PAIR_COUNT_EN
    logic [31:0]      pair_count;
`endif

    half_shell_pair_scheduler #(
        .NUM_NEIGHBOR_CELLS (NB),
        .PARTICLE_ID_WIDTH  (PID_W),
        .RD_LATENCY         (RD_LAT),
        .SEL_WIDTH          (SEL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_particles (num_particles),
        .pe_ready      (pe_ready),
        .ref_rd_en     (ref_rd_en),
        .ref_rd_addr   (ref_rd_addr),
        .nb_rd_en      (nb_rd_en),
        .nb_rd_addr    (nb_rd_addr),
        .nb_sel        (nb_sel),
        .pair_valid    (pair_valid),
        .ref_last      (ref_last),
        .busy          (busy),
`ifdef PAIR_COUNT_EN
        .pair_count    (pair_count),
`endif
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Observation log, filled by the monitor at negedge+1.
    logic [13:0] iss_q[$];
    logic [4:0]  pv_q[$];
    logic [18:0] exp_q[$];
    logic [15:0] hist;
    int cycle = 0;
    int acc_starts, start_cycle, first_iss, last_iss, last_pv;
    int done_cnt, done_cycle, busy_cycles, stall_viol, en_mis, gap_mis;

    task automatic clear_logs();
        iss_q.delete();
        pv_q.delete();
        acc_starts = 0; start_cycle = 0; first_iss = -1; last_iss = 0; last_pv = 0;
        done_cnt = 0; done_cycle = 0; busy_cycles = 0;
        stall_viol = 0; en_mis = 0; gap_mis = 0;
    endtask

    always begin
        @(negedge clk);
        #1;
        cycle++;
        if (rst) begin
            hist = '0;
        end else begin
            if (start && !busy) begin
                acc_starts++;
                start_cycle = cycle;
            end
            if (ref_rd_en) begin
                iss_q.push_back({ref_rd_addr, nb_rd_addr});
                if (first_iss < 0) first_iss = cycle;
                last_iss = cycle;
                if (!pe_ready) stall_viol++;
            end
            if (ref_rd_en !== nb_rd_en) en_mis++;
            if (pair_valid) begin
                pv_q.push_back({nb_sel, ref_last});
                last_pv = cycle;
            end
            if (pair_valid !== hist[RD_LAT-1]) gap_mis++;
            hist = {hist[14:0], ref_rd_en};
            if (done) begin
                done_cnt++;
                done_cycle = cycle;
            end
            if (busy) busy_cycles++;
        end
    end

    task automatic build_exp(input int n);
        exp_q.delete();
        for (int r = 0; r < n; r++)
            for (int s = 0; s <= NB; s++)
                for (int p = (s == 0) ? r + 1 : 0; p < n; p++)
                    exp_q.push_back({PID_W'(r), PID_W'(p), SEL_W'(s), (s == NB) && (p == n - 1)});
    endtask

    task automatic check_iter(input int n, input int mode, input bit saw_done);
        string t;
        int cnt;
        t = $sformatf("N%0d_m%0d", n, mode);
        chk({t, "_done_seen"}, 32'(saw_done), 32'd1);
        chk({t, "_issue_count"}, iss_q.size(), exp_q.size());
        chk({t, "_pair_count"}, pv_q.size(), exp_q.size());
        cnt = (iss_q.size() < pv_q.size()) ? iss_q.size() : pv_q.size();
        if (cnt > exp_q.size()) cnt = exp_q.size();
        for (int i = 0; i < cnt; i++)
            chk($sformatf("%s_pair%0d", t, i), 32'({iss_q[i], pv_q[i]}), 32'(exp_q[i]));
        chk({t, "_done_count"}, done_cnt, 1);
        chk({t, "_accepted_starts"}, acc_starts, 1);
        chk({t, "_busy_window"}, busy_cycles, done_cycle - start_cycle);
        chk({t, "_issue_while_stalled"}, stall_viol, 0);
        chk({t, "_rd_en_match"}, en_mis, 0);
        chk({t, "_valid_alignment"}, gap_mis, 0);
        if (exp_q.size() > 0) begin
            chk({t, "_done_after_last_pair"}, done_cycle, last_pv + 1);
            if (mode != 1) begin
                chk({t, "_first_issue"}, first_iss, start_cycle + 1);
                chk({t, "_back_to_back"}, last_iss - first_iss + 1, exp_q.size());
            end
        end else begin
            chk({t, "_done_latency_ok"}, 32'(done_cycle - start_cycle <= RD_LAT + 2), 32'd1);
        end
`ifdef PAIR_COUNT_EN
        chk({t, "_pair_count_out"}, pair_count, exp_q.size());
`endif
    endtask

    // mode 0: pe_ready high; 1: pe_ready toggles, num_particles changed mid-run;
    // 2: start re-pulsed mid-run and in the done cycle.
    task automatic run_iter(input int n, input int mode);
        bit saw_done;
        saw_done = 1'b0;
        clear_logs();
        build_exp(n);
        @(negedge clk);
        num_particles = 8'(n);
        start = 1'b1;
        pe_ready = 1'b1;
        for (int c = 0; c < 2000 && !saw_done; c++) begin
            @(negedge clk);
            saw_done = done;
            start = (mode == 2) && (c == 10 || done);
            pe_ready = (mode == 1) ? c[0] : 1'b1;
            if (mode == 1 && c == 20) num_particles = 8'd5;
        end
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
            pe_ready = 1'b1;
        end
        #2;
        check_iter(n, mode, saw_done);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pe_ready = 1'b0;
        num_particles = '0;
        clear_logs();
        #3;
        chk("reset_outputs", 32'({ref_rd_en, nb_rd_en, ref_rd_addr, nb_rd_addr, nb_sel,
                                  pair_valid, ref_last, busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_after_reset", 32'({busy, done, pair_valid, ref_rd_en}), 32'd0);

        run_iter(0, 0);
        run_iter(1, 0);
        run_iter(3, 0);
        run_iter(3, 1);
        run_iter(2, 2);

        // Abort an N=4 iteration mid-RUN with an asynchronous reset.
        clear_logs();
        @(negedge clk);
        num_particles = 8'd4;
        start = 1'b1;
        pe_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        chk("midrun_busy_before_rst", 32'({busy, ref_rd_en, pair_valid}), 32'h7);
        rst = 1'b1;
        #1;
        chk("midrun_async_reset_outputs", 32'({ref_rd_en, nb_rd_en, ref_rd_addr, nb_rd_addr,
                                               nb_sel, pair_valid, ref_last, busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        chk("aborted_no_done", done_cnt, 0);
        chk("aborted_idle", 32'(busy), 32'd0);
        run_iter(4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
